// File: rtl/mux256to1_sel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux256to1_sel_pkg : shared sizing constants and types for the bit selector
// Rev 1.0
// ---------------------------------------------------------------------------
package mux256to1_sel_pkg;

    localparam int DEF_SEL_W = 8;
    localparam int DEF_N     = 2 ** DEF_SEL_W;

    typedef logic [DEF_SEL_W-1:0] sel_t;
    typedef logic [DEF_N-1:0]     din_t;

endpackage : mux256to1_sel_pkg
`default_nettype wire

// File: rtl/mux256to1_sel_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux256to1_sel_if : data/select/result bundle for the bit selector
// Rev 1.0
// ---------------------------------------------------------------------------
interface mux256to1_sel_if
    import mux256to1_sel_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
);
    localparam int N = 2 ** SEL_W;

    logic [N-1:0]     din;
    logic [SEL_W-1:0] sel;
    logic             dout;
    logic             dout_q;

    modport master (output din, output sel, input dout, input dout_q);
    modport slave  (input din, input sel, output dout, output dout_q);

endinterface : mux256to1_sel_if
`default_nettype wire

// File: rtl/mux256to1_sel_mux2_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux2_stage : one tree level, picks the even or odd bit of every pair
// Rev 1.0
// ---------------------------------------------------------------------------
module mux2_stage #(
    parameter int WIDTH = 1
) (
    input  wire logic [2*WIDTH-1:0] in_i,
    input  wire logic               sel_i,
    output      logic [WIDTH-1:0]   out_o
);

    for (genvar j = 0; j < WIDTH; j++) begin : g_pair
        // Ternary keeps an X on the unselected bit from reaching the output
        assign out_o[j] = sel_i ? in_i[2*j+1] : in_i[2*j];
    end

endmodule : mux2_stage
`default_nettype wire

// File: rtl/mux256to1_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux256to1_sel : N:1 single-bit selector built as a SEL_W-level 2:1 tree,
//                 plus a registered copy of the result. Rev 1.0
// ---------------------------------------------------------------------------
module mux256to1_sel
    import mux256to1_sel_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mux256to1_sel_if.slave  bus
);

    localparam int N       = 2 ** SEL_W;
    localparam int TREE_W  = 2 * N - 1;

    // All tree levels packed back to back: level k is N>>k bits wide and
    // starts at bit 2N - 2*(N>>k); the last level is the single result bit.
    logic [TREE_W-1:0] w_tree;
    logic              dout_d;
    logic              dout_q;

    assign w_tree[N-1:0] = bus.din;

    for (genvar k = 0; k < SEL_W; k++) begin : g_stage
        localparam int IN_W    = N >> k;
        localparam int OUT_W   = N >> (k + 1);
        localparam int IN_OFF  = 2 * N - 2 * IN_W;
        localparam int OUT_OFF = 2 * N - 2 * OUT_W;

        mux2_stage #(
            .WIDTH (OUT_W)
        ) u_stage (
            .in_i  (w_tree[IN_OFF +: IN_W]),
            .sel_i (bus.sel[k]),
            .out_o (w_tree[OUT_OFF +: OUT_W])
        );
    end

    assign dout_d   = w_tree[TREE_W-1];
    assign bus.dout = dout_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.dout_q = dout_q;

endmodule : mux256to1_sel
`default_nettype wire

// File: tb/tb_mux256to1_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux256to1_sel : directed and random checks of the 256:1 bit selector
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mux256to1_sel;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mux256to1_sel_if #(.SEL_W(8)) bus ();

    mux256to1_sel #(
        .SEL_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [255:0] din_v;
    logic [7:0]   sel_v;
    logic         exp_v;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.din   = '0;
        bus.sel   = '0;

        // Reset state of the register
        @(posedge clk); #1;
        check("reset_dout_q", bus.dout_q, 1'b0);
        check("reset_dout", bus.dout, 1'b0);

        // Walking one
        for (int s = 0; s < 256; s++) begin
            din_v    = '0;
            din_v[s] = 1'b1;
            bus.din  = din_v;
            bus.sel  = 8'(s);
            #1;
            check($sformatf("walk1_hit[%0d]", s), bus.dout, 1'b1);
            bus.sel  = 8'(s + 1);
            #1;
            check($sformatf("walk1_miss[%0d]", s), bus.dout, 1'b0);
        end

        // Walking zero
        for (int s = 0; s < 256; s++) begin
            din_v    = '1;
            din_v[s] = 1'b0;
            bus.din  = din_v;
            bus.sel  = 8'(s);
            #1;
            check($sformatf("walk0_hit[%0d]", s), bus.dout, 1'b0);
            bus.sel  = 8'(s) ^ 8'd1;
            #1;
            check($sformatf("walk0_nbr[%0d]", s), bus.dout, 1'b1);
        end

        // Boundaries
        bus.din = {1'b1, 254'b0, 1'b1};
        bus.sel = 8'd0;   #1; check("bound_sel0",   bus.dout, 1'b1);
        bus.sel = 8'd255; #1; check("bound_sel255", bus.dout, 1'b1);
        bus.sel = 8'd1;   #1; check("bound_sel1",   bus.dout, 1'b0);
        bus.sel = 8'd128; #1; check("bound_sel128", bus.dout, 1'b0);

        // Random regression, a new sample every half-period on both edges
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk or negedge clk);
            #1;
            din_v   = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
            sel_v   = 8'($urandom_range(0, 255));
            bus.din = din_v;
            bus.sel = sel_v;
            exp_v   = 1'((din_v >> sel_v) & 256'd1);
            #1;
            check($sformatf("random[%0d]", i), bus.dout, exp_v);
        end

        // Reset and register behaviour
        @(negedge clk);
        reset   = 1'b1;
        din_v   = '0;
        din_v[5] = 1'b1;
        bus.din = din_v;
        bus.sel = 8'd5;
        @(posedge clk); #1;
        check("rst_edge1_dout",   bus.dout,   1'b1);
        check("rst_edge1_dout_q", bus.dout_q, 1'b0);
        @(posedge clk); #1;
        check("rst_edge2_dout",   bus.dout,   1'b1);
        check("rst_edge2_dout_q", bus.dout_q, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_release_hold", bus.dout_q, 1'b0);
        @(posedge clk); #1;
        check("capture_one", bus.dout_q, 1'b1);
        bus.sel = 8'd6;
        #1;
        check("sel6_dout",        bus.dout,   1'b0);
        check("sel6_dout_q_hold", bus.dout_q, 1'b1);
        @(posedge clk); #1;
        check("sel6_dout_q", bus.dout_q, 1'b0);

        // Reset wins over capture with dout = 1
        bus.sel = 8'd5;
        reset   = 1'b1;
        @(posedge clk); #1;
        check("rst_priority", bus.dout_q, 1'b0);
        reset = 1'b0;

        // X on an unselected input must stay isolated
        din_v      = '0;
        din_v[200] = 1'bx;
        bus.din    = din_v;
        bus.sel    = 8'd3;
        #1;
        check("x_isolation", bus.dout, 1'b0);
        bus.sel    = 8'd201;
        #1;
        check("x_isolation_nbr", bus.dout, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux256to1_sel
`default_nettype wire
